// File: rtl/router_pkg.sv
// rtl/router_pkg.sv - shared router constants, FIFO word type and header-length helper
package router_pkg;

    localparam int ROUTER_DATA_W     = 8;
    localparam int ROUTER_FIFO_DEPTH = 16;

    // Packet counter holds header length (6 bits) plus one for the parity byte.
    localparam int PKT_CNT_W = 7;

    typedef struct packed {
        logic       hdr;
        logic [7:0] data;
    } fifo_word_t;

    // Payload length field carried in bits [7:2] of a header byte.
    function automatic logic [5:0] hdr_len(input logic [7:0] b);
        return 6'(b >> 2);
    endfunction

endpackage

// File: rtl/router_out_fifo.sv
// rtl/router_out_fifo.sv - per-destination output FIFO of the 1x3 router with packet-length tracking
//
// Ports:
//   clock      rising-edge clock
//   rst        synchronous active-high reset
//   soft_rst   synchronous flush of this FIFO (same effect as rst)
//   write_enb  write request for data_in
//   lfd_state  marks data_in as a packet header byte
//   data_in    byte to store
//   read_enb   read request from the destination
//   data_out   registered read data
//   vld_out    FIFO non-empty
//   full       DEPTH entries occupied
//   empty      zero entries occupied
//   occupancy  wr_ptr - rd_ptr (only with ROUTER_OUT_FIFO_OCCUPANCY_EN defined)
//
// Optional feature macro: ROUTER_OUT_FIFO_OCCUPANCY_EN adds the occupancy port
// and occupancy consistency assertions.
module router_out_fifo
    import router_pkg::*;
#(
    parameter int DEPTH  = ROUTER_FIFO_DEPTH,
    parameter int DATA_W = ROUTER_DATA_W
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              soft_rst,
    input  logic              write_enb,
    input  logic              lfd_state,
    input  logic [DATA_W-1:0] data_in,
    input  logic              read_enb,
    output logic [DATA_W-1:0] data_out,
    output logic              vld_out,
    output logic              full,
    output logic              empty
`ifdef ROUTER_OUT_FIFO_OCCUPANCY_EN
    ,
    output logic [$clog2(DEPTH):0] occupancy
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]          PTR_ONE = (AW+1)'(1);
    localparam logic [PKT_CNT_W-1:0] CNT_ONE = PKT_CNT_W'(1);

    logic [DATA_W:0]      mem [DEPTH];
    logic [AW:0]          wr_ptr;
    logic [AW:0]          rd_ptr;
    logic [DATA_W:0]      rd_word;
    logic [PKT_CNT_W-1:0] pkt_cnt;
    logic                 zero_pend;
    logic                 wr_acc;
    logic                 rd_acc;
    logic                 flush;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign vld_out = !empty;

    assign flush   = rst || soft_rst;
    assign wr_acc  = write_enb && !full;
    assign rd_acc  = read_enb && !empty;
    assign rd_word = mem[rd_ptr[AW-1:0]];

    // Storage carries no reset; contents behind the read pointer are don't-care.
    always_ff @(posedge clock) begin
        if (wr_acc && !flush) begin
            mem[wr_ptr[AW-1:0]] <= {lfd_state, data_in};
        end
    end

    always_ff @(posedge clock) begin
        if (flush) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            pkt_cnt   <= '0;
            zero_pend <= 1'b0;
            data_out  <= '0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (rd_acc) begin
                rd_ptr   <= rd_ptr + PTR_ONE;
                data_out <= rd_word[DATA_W-1:0];
                if (rd_word[DATA_W]) begin
                    // Header: count payload bytes plus the trailing parity byte.
                    pkt_cnt   <= {1'b0, hdr_len(rd_word[7:0])} + CNT_ONE;
                    zero_pend <= 1'b0;
                end else begin
                    // Remember that the last byte of the packet just went out so
                    // the bus can be cleared if the destination stops reading.
                    zero_pend <= (pkt_cnt == CNT_ONE);
                    if (pkt_cnt != '0) begin
                        pkt_cnt <= pkt_cnt - CNT_ONE;
                    end
                end
            end else begin
                if (zero_pend) begin
                    data_out <= '0;
                end
                zero_pend <= 1'b0;
            end
        end
    end

`ifdef ROUTER_OUT_FIFO_OCCUPANCY_EN
    localparam logic [AW:0] OCC_MAX = (AW+1)'(DEPTH);

    assign occupancy = wr_ptr - rd_ptr;

    a_occ_bound: assert property (@(posedge clock) disable iff (flush)
        occupancy <= OCC_MAX);
    a_occ_full: assert property (@(posedge clock) disable iff (flush)
        full |-> (occupancy == OCC_MAX));
    a_occ_empty: assert property (@(posedge clock) disable iff (flush)
        empty |-> (occupancy == '0));
`endif

endmodule

// File: tb/tb_router_out_fifo.sv
// tb/tb_router_out_fifo.sv - self-checking bench for router_out_fifo
module tb_router_out_fifo;
    import router_pkg::*;

    localparam int DEPTH = 16;

    logic       clock;
    logic       rst;
    logic       soft_rst;
    logic       write_enb;
    logic       lfd_state;
    logic [7:0] data_in;
    logic       read_enb;
    logic [7:0] data_out;
    logic       vld_out;
    logic       full;
    logic       empty;
`ifdef ROUTER_OUT_FIFO_OCCUPANCY_EN
    logic [4:0] occupancy;
`endif

    int checks;
    int errors;

    // Scoreboard and read-side reference state.
    fifo_word_t sb[$];
    int         m_pkt;
    logic [7:0] m_dout;
    bit         m_zp;

    router_out_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
        .clock     (clock),
        .rst       (rst),
        .soft_rst  (soft_rst),
        .write_enb (write_enb),
        .lfd_state (lfd_state),
        .data_in   (data_in),
        .read_enb  (read_enb),
        .data_out  (data_out),
        .vld_out   (vld_out),
        .full      (full),
        .empty     (empty)
`ifdef ROUTER_OUT_FIFO_OCCUPANCY_EN
        ,
        .occupancy (occupancy)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // One clock of stimulus; the reference is updated from the scoreboard and
    // all outputs are compared 1 ns after the edge.
    task automatic cycle(input bit rs, input bit srst, input bit we, input bit lfd,
                         input logic [7:0] din, input bit re, input string tag);
        bit         wacc;
        bit         racc;
        fifo_word_t w;
        rst       = rs;
        soft_rst  = srst;
        write_enb = we;
        lfd_state = lfd;
        data_in   = din;
        read_enb  = re;
        if (rs || srst) begin
            sb.delete();
            m_pkt  = 0;
            m_dout = 8'h00;
            m_zp   = 1'b0;
        end else begin
            racc = re && (sb.size() != 0);
            wacc = we && (sb.size() != DEPTH);
            if (racc) begin
                w      = sb.pop_front();
                m_dout = w.data;
                if (w.hdr) begin
                    m_pkt = int'(w.data[7:2]) + 1;
                    m_zp  = 1'b0;
                end else begin
                    m_zp = (m_pkt == 1);
                    if (m_pkt > 0) m_pkt--;
                end
            end else begin
                if (m_zp) m_dout = 8'h00;
                m_zp = 1'b0;
            end
            if (wacc) begin
                w.hdr  = lfd;
                w.data = din;
                sb.push_back(w);
            end
        end
        @(posedge clock);
        #1;
        checks++;
        if (data_out !== m_dout) begin
            errors++;
            $display("FAIL %s data_out: got %02h expected %02h", tag, data_out, m_dout);
        end
        checks++;
        if (empty !== (sb.size() == 0)) begin
            errors++;
            $display("FAIL %s empty: got %b expected %b", tag, empty, sb.size() == 0);
        end
        checks++;
        if (full !== (sb.size() == DEPTH)) begin
            errors++;
            $display("FAIL %s full: got %b expected %b", tag, full, sb.size() == DEPTH);
        end
        checks++;
        if (vld_out !== (sb.size() != 0)) begin
            errors++;
            $display("FAIL %s vld_out: got %b expected %b", tag, vld_out, sb.size() != 0);
        end
        rst       = 1'b0;
        soft_rst  = 1'b0;
        write_enb = 1'b0;
        lfd_state = 1'b0;
        read_enb  = 1'b0;
    endtask

    task automatic wr(input bit lfd, input logic [7:0] d, input string tag);
        cycle(1'b0, 1'b0, 1'b1, lfd, d, 1'b0, tag);
    endtask

    task automatic rd(input string tag);
        cycle(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, tag);
    endtask

    // Reads until the DUT reports empty, bounded so a stuck flag cannot hang.
    task automatic drain(output int n, input string tag);
        n = 0;
        while (empty === 1'b0 && n < 40) begin
            rd(tag);
            n++;
        end
    endtask

    task automatic test_reset();
        cycle(1'b1, 1'b0, 1'b1, 1'b1, 8'hC3, 1'b0, "reset0");
        cycle(1'b1, 1'b0, 1'b1, 1'b0, 8'h3C, 1'b0, "reset1");
        checks++;
        if (empty !== 1'b1 || full !== 1'b0 || vld_out !== 1'b0 || data_out !== 8'h00) begin
            errors++;
            $display("FAIL reset_state: got e=%b f=%b v=%b d=%02h expected e=1 f=0 v=0 d=00",
                     empty, full, vld_out, data_out);
        end
    endtask

    task automatic test_single_packet();
        logic [7:0] exp_seq [6];
        exp_seq = '{8'h0D, 8'hA1, 8'hA2, 8'hA3, 8'h55, 8'h00};
        wr(1'b1, 8'h0D, "pkt_hdr");
        wr(1'b0, 8'hA1, "pkt_p1");
        wr(1'b0, 8'hA2, "pkt_p2");
        wr(1'b0, 8'hA3, "pkt_p3");
        wr(1'b0, 8'h55, "pkt_par");
        for (int i = 0; i < 6; i++) begin
            rd("pkt_read");
            checks++;
            if (data_out !== exp_seq[i]) begin
                errors++;
                $display("FAIL pkt_seq[%0d]: got %02h expected %02h", i, data_out, exp_seq[i]);
            end
            if (i == 4) begin
                checks++;
                if (empty !== 1'b1) begin
                    errors++;
                    $display("FAIL pkt_empty_after_last: got %b expected 1", empty);
                end
            end
        end
    endtask

    task automatic fill_and_check(input logic [7:0] base, input string tag);
        int n;
        for (int i = 0; i < DEPTH; i++) wr(1'b0, base + 8'(i), tag);
        checks++;
        if (full !== 1'b1) begin
            errors++;
            $display("FAIL %s full_after_16: got %b expected 1", tag, full);
        end
        wr(1'b0, 8'hFF, "overflow_write");
        n = 0;
        while (empty === 1'b0 && n < 40) begin
            rd(tag);
            checks++;
            if (data_out !== base + 8'(n)) begin
                errors++;
                $display("FAIL %s drain[%0d]: got %02h expected %02h", tag, n, data_out, base + 8'(n));
            end
            n++;
        end
        checks++;
        if (n != DEPTH) begin
            errors++;
            $display("FAIL %s drain_count: got %0d expected %0d", tag, n, DEPTH);
        end
    endtask

    task automatic test_fill_overflow();
        fill_and_check(8'h10, "fill1");
        fill_and_check(8'h80, "fill2");
    endtask

    task automatic test_simultaneous();
        int n;
        for (int i = 0; i < DEPTH; i++) wr(1'b0, 8'h20 + 8'(i), "sim_fill");
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'hEE, 1'b1, "sim_full_rw");
        checks++;
        if (data_out !== 8'h20 || full !== 1'b0) begin
            errors++;
            $display("FAIL sim_full_rw: got d=%02h f=%b expected d=20 f=0", data_out, full);
        end
        drain(n, "sim_drain");
        checks++;
        if (n != DEPTH - 1) begin
            errors++;
            $display("FAIL sim_full_drain_count: got %0d expected %0d", n, DEPTH - 1);
        end
        for (int i = 0; i < 5; i++) wr(1'b0, 8'h40 + 8'(i), "sim_five");
        cycle(1'b0, 1'b0, 1'b1, 1'b0, 8'h45, 1'b1, "sim_mid_rw");
        checks++;
        if (data_out !== 8'h40) begin
            errors++;
            $display("FAIL sim_mid_rw_data: got %02h expected 40", data_out);
        end
        drain(n, "sim_mid_drain");
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL sim_mid_count: got %0d expected 5", n);
        end
        cycle(1'b0, 1'b0, 1'b1, 1'b1, 8'h09, 1'b1, "sim_empty_rw");
        checks++;
        if (empty !== 1'b0) begin
            errors++;
            $display("FAIL sim_empty_rw_stored: got empty=%b expected 0", empty);
        end
        drain(n, "sim_empty_drain");
    endtask

    task automatic test_soft_reset();
        logic [7:0] exp_seq [4];
        exp_seq = '{8'h05, 8'h77, 8'h33, 8'h00};
        wr(1'b1, 8'h12, "srst_hdr");
        wr(1'b0, 8'h01, "srst_p");
        wr(1'b0, 8'h02, "srst_p");
        wr(1'b0, 8'h03, "srst_p");
        wr(1'b0, 8'h04, "srst_p");
        wr(1'b0, 8'h99, "srst_par");
        rd("srst_rd");
        rd("srst_rd");
        rd("srst_rd");
        cycle(1'b0, 1'b1, 1'b1, 1'b0, 8'hBB, 1'b1, "srst_pulse");
        checks++;
        if (empty !== 1'b1 || data_out !== 8'h00 || vld_out !== 1'b0) begin
            errors++;
            $display("FAIL srst_state: got e=%b d=%02h v=%b expected e=1 d=00 v=0",
                     empty, data_out, vld_out);
        end
        wr(1'b1, 8'h05, "srst_new_hdr");
        wr(1'b0, 8'h77, "srst_new_p");
        wr(1'b0, 8'h33, "srst_new_par");
        for (int i = 0; i < 4; i++) begin
            rd("srst_new_rd");
            checks++;
            if (data_out !== exp_seq[i]) begin
                errors++;
                $display("FAIL srst_new_seq[%0d]: got %02h expected %02h", i, data_out, exp_seq[i]);
            end
        end
    endtask

    task automatic test_read_empty();
        wr(1'b0, 8'h5A, "re_wr");
        rd("re_rd");
        for (int i = 0; i < 3; i++) begin
            rd("re_empty");
            checks++;
            if (data_out !== 8'h5A || vld_out !== 1'b0) begin
                errors++;
                $display("FAIL read_empty_hold: got d=%02h v=%b expected d=5A v=0", data_out, vld_out);
            end
        end
        wr(1'b0, 8'h6B, "re_wr2");
        rd("re_rd2");
        checks++;
        if (data_out !== 8'h6B || empty !== 1'b1) begin
            errors++;
            $display("FAIL read_empty_ptrs: got d=%02h e=%b expected d=6B e=1", data_out, empty);
        end
    endtask

    initial begin
        checks    = 0;
        errors    = 0;
        m_pkt     = 0;
        m_dout    = 8'h00;
        m_zp      = 1'b0;
        rst       = 1'b1;
        soft_rst  = 1'b0;
        write_enb = 1'b0;
        lfd_state = 1'b0;
        data_in   = 8'h00;
        read_enb  = 1'b0;
        test_reset();
        test_single_packet();
        test_fill_overflow();
        test_simultaneous();
        test_soft_reset();
        test_read_empty();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
